// File: rtl/adc_frame_gen.sv
// ---------------------------------------------------------------------------
// adc_frame_gen
//
// Cuts a continuous multi-channel ADC sample stream into fixed-length AXIS
// frames for the windowing stage. The final sample of every frame carries
// TLAST. The window stage resets its coefficient address on TLAST, so a
// frame is never truncated. Once a frame has started, it always runs to
// FRAME_LEN samples, even if stop is requested partway through.
//
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   start             one-cycle pulse, arms capture (latches num_frames and
//                     gap_cycles); ignored while busy
//   stop              one-cycle pulse, ends capture after the current frame
//   num_frames        frames per capture, 0 = continuous until stop
//   gap_cycles        idle clocks inserted between frames
//   adc_valid         sample-present qualifier
//   adc_data          CHANNELS packed 16-bit lanes, lane i = [i*16 +: 16]
//   M_AXIS_TVALID     frame data valid (1 clock after the accepted sample)
//   M_AXIS_TDATA      registered copy of adc_data
//   M_AXIS_TLAST      final sample of a frame
//   M_AXIS_TREADY     monitored only; feeds the overflow flag
//   busy              high whenever the FSM is not IDLE
//   frame_count       frames completed since last start, saturating
//   overflow          sticky, TVALID seen while TREADY low
// ---------------------------------------------------------------------------
module adc_frame_gen #(
    parameter int CHANNELS  = 4,
    parameter int FRAME_LEN = 2048,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [15:0]             num_frames,
    input  logic [15:0]             gap_cycles,
    input  logic                    adc_valid,
    input  logic [CHANNELS*16-1:0]  adc_data,
    output logic                    M_AXIS_TVALID,
    output logic [CHANNELS*16-1:0]  M_AXIS_TDATA,
    output logic                    M_AXIS_TLAST,
    input  logic                    M_AXIS_TREADY,
    output logic                    busy,
    output logic [15:0]             frame_count,
    output logic                    overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] sample_cnt;
    logic [15:0]      gap_cnt;
    logic [15:0]      nf_q;
    logic [15:0]      gap_q;
    logic             stop_req;

    logic             take;
    logic             eof;
    logic [15:0]      fc_inc;
    logic             end_capture;
    logic             start_ok;

    // A sample is only consumed in RUN; in IDLE and GAP it is dropped.
    assign take     = (state == S_RUN) && adc_valid;
    assign eof      = take && (sample_cnt == LAST_IDX);
    assign start_ok = (state == S_IDLE) && start;

    // Saturating increment; the end-of-capture compare uses the new value.
    assign fc_inc = (frame_count == 16'hFFFF) ? frame_count : frame_count + 16'd1;

    // A stop pulse landing on the final sample itself also ends the capture,
    // since the frame is already complete at that point.
    assign end_capture = stop_req || stop || ((nf_q != 16'd0) && (fc_inc == nf_q));

    assign busy = (state != S_IDLE);

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            sample_cnt  <= '0;
            gap_cnt     <= 16'd0;
            nf_q        <= 16'd0;
            gap_q       <= 16'd0;
            stop_req    <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        nf_q        <= num_frames;
                        gap_q       <= gap_cycles;
                        frame_count <= 16'd0;
                        sample_cnt  <= '0;
                        // start+stop together: one frame, then stop
                        stop_req    <= stop;
                        state       <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (stop) begin
                        stop_req <= 1'b1;
                    end
                    if (take) begin
                        sample_cnt <= eof ? '0 : sample_cnt + CNT_W'(1);
                    end
                    if (eof) begin
                        frame_count <= fc_inc;
                        if (end_capture) begin
                            state <= S_IDLE;
                        end else if (gap_q != 16'd0) begin
                            state   <= S_GAP;
                            gap_cnt <= gap_q;
                        end
                    end
                end

                S_GAP: begin
                    if (stop || stop_req) begin
                        stop_req <= 1'b1;
                        state    <= S_IDLE;
                    end else if (gap_cnt <= 16'd1) begin
                        // last idle clock; sample_cnt already wrapped to 0
                        state <= S_RUN;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output datapath: exactly one clock of latency, never stalled.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TDATA  <= '0;
        end else begin
            M_AXIS_TVALID <= take;
            M_AXIS_TLAST  <= eof;
            if (take) begin
                M_AXIS_TDATA <= adc_data;
            end
        end
    end

    // Sticky overflow. An accepted start clears it, and the clear wins over
    // a coincident set, so each capture begins with a clean flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (start_ok) begin
            overflow <= 1'b0;
        end else if (M_AXIS_TVALID && !M_AXIS_TREADY) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_frame_gen.sv
module tb_adc_frame_gen;

    localparam int CH = 4;
    localparam int FL = 8;
    localparam int DW = CH * 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [15:0]   num_frames = 16'd0;
    logic [15:0]   gap_cycles = 16'd0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tready = 1'b1;
    logic          busy;
    logic [15:0]   frame_count;
    logic          overflow;

    always #5 clk = ~clk;

    adc_frame_gen #(.CHANNELS(CH), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .num_frames(num_frames), .gap_cycles(gap_cycles),
        .adc_valid(adc_valid), .adc_data(adc_data),
        .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TLAST(tlast),
        .M_AXIS_TREADY(tready), .busy(busy), .frame_count(frame_count),
        .overflow(overflow)
    );

    typedef struct {
        int nf; int gap; bit toggle; bit stop_w_start;
        int stop_frame; int stop_idx; int rdy_low; int restart;
        int exp_beats; int exp_frames; int exp_gap; bit exp_ovf;
    } vec_t;

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;

    beat_t sb[$];
    beat_t e;
    vec_t  vt[6];

    int n_chk = 0, n_fail = 0;
    int beats = 0, cyc = 0, last_tl = -1, exp_gap = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] dat(input int tag, input int it);
        logic [15:0] w;
        w = 16'(tag * 256 + it);
        return {CH{w}};
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every output beat must match the next expected one.
    always @(negedge clk) begin
        if (!rst && tvalid) begin
            beats++;
            if (sb.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                e = sb.pop_front();
                check("tdata", tdata, e.data);
                check("tlast", tlast, e.last);
            end
            if (last_tl >= 0 && exp_gap >= 0) begin
                check("gap_len", cyc - last_tl - 1, exp_gap);
                last_tl = -1;
            end
            if (tlast) last_tl = cyc;
        end
    end

    // Drive one capture and predict the accepted samples from the
    // frame/gap/stop rules.
    task automatic run_vec(input vec_t v, input int tag);
        int frames, idx, g, phase, post;
        bit stopping, val;
        frames = 0; idx = 0; g = 0; post = 0;
        beats = 0; last_tl = -1; exp_gap = v.exp_gap;
        @(posedge clk); #1;
        start = 1'b1; num_frames = 16'(v.nf); gap_cycles = 16'(v.gap);
        stop = v.stop_w_start; stopping = v.stop_w_start;
        adc_valid = !v.toggle; adc_data = dat(tag, 0);
        phase = 1;
        for (int it = 1; it < 400 && post < 6; it++) begin
            @(posedge clk); #1;
            start = (it == v.restart);
            if (start) begin num_frames = 16'd1; gap_cycles = 16'd0; end
            stop = 1'b0;
            tready = (it != v.rdy_low);
            if (it == 1) begin
                check("busy_after_start", busy, 1);
                check("overflow_after_start", overflow, 0);
            end
            val = v.toggle ? (it % 2 == 1) : 1'b1;
            adc_valid = val;
            adc_data = dat(tag, it);
            if (phase == 1 && val) begin
                if (frames == v.stop_frame && idx == v.stop_idx) begin
                    stop = 1'b1; stopping = 1'b1;
                end
                sb.push_back('{adc_data, (idx == FL - 1)});
                idx++;
                if (idx == FL) begin
                    idx = 0; frames++;
                    if (stopping || (v.nf != 0 && frames == v.nf)) phase = 0;
                    else if (v.gap != 0) begin phase = 2; g = v.gap; end
                end
            end else if (phase == 2) begin
                if (g == 1) phase = 1; else g--;
            end else if (phase == 0) begin
                post++;
            end
        end
        tready = 1'b1; adc_valid = 1'b0; start = 1'b0; stop = 1'b0;
        check("leftover_beats", sb.size(), 0);
        sb.delete();
        check("beats", beats, v.exp_beats);
        check("frame_count", frame_count, v.exp_frames);
        check("busy_end", busy, 0);
        check("overflow_end", overflow, v.exp_ovf);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //         nf gap tog sws sf si rl rs beats fr gap ovf
        vt[0] = '{2, 0, 0, 0, -1, -1, -1, -1, 16, 2, 0, 0};
        vt[1] = '{3, 5, 0, 0, -1, -1, -1, 10, 24, 3, 5, 0};
        vt[2] = '{1, 0, 1, 0, -1, -1,  2, -1,  8, 1, -1, 1};
        vt[3] = '{0, 0, 0, 0,  1,  3, -1, -1, 16, 2, 0, 0};
        vt[4] = '{5, 0, 0, 1, -1, -1, -1, -1,  8, 1, 0, 0};
        vt[5] = '{2, 1, 0, 0, -1, -1, -1, -1, 16, 2, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        // stop while idle must do nothing
        stop = 1'b1; adc_valid = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_busy", busy, 0);
        check("idle_no_beats", beats, 0);
        adc_valid = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vt[i], i + 1);

        // Reset asserted in the middle of a frame
        beats = 0; last_tl = -1; exp_gap = 0;
        @(posedge clk); #1;
        start = 1'b1; num_frames = 16'd0; gap_cycles = 16'd0;
        adc_valid = 1'b1; adc_data = dat(9, 0);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            adc_data = dat(9, i);
            if (i <= 4) sb.push_back('{adc_data, 1'b0});
        end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_tvalid", tvalid, 0);
        check("midrst_tlast", tlast, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_count", frame_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_leftover", sb.size(), 0);
        check("midrst_beats", beats, 4);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        check("midrst_idle_beats", beats, 4);
        check("midrst_idle_busy", busy, 0);
        adc_valid = 1'b0;
        run_vec('{1, 0, 0, 0, -1, -1, -1, -1, 8, 1, 0, 0}, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
